bcd_display_ctrl: RTL and testbench

Arbitrates two requesters (A = SAD result, B = auxiliary counter) for the single shared combinational binary-to-BCD converter. Sequences each conversion and holds the resulting three digits in display registers. Time-multiplexes those digits onto a 3-digit seven-segment scan interface with leading-zero blanking. The block sits between the datapath result sources and the segment decoder.

---
 rtl/bcd_display_ctrl.sv | 171 +++++++++++++++++
 tb/tb_bcd_display_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_ctrl.sv
// Round-robin front end for a shared binary-to-BCD converter.
// Holds the converted digits and scans them onto a 3-digit seven-segment display.
module bcd_display_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int NUM_WIDTH   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_a,
  input  logic [NUM_WIDTH-1:0] num_a,
  output logic                 ack_a,
  input  logic                 req_b,
  input  logic [NUM_WIDTH-1:0] num_b,
  output logic                 ack_b,
  output logic [NUM_WIDTH-1:0] conv_number,
  input  logic [3:0]           conv_bcd0,
  input  logic [3:0]           conv_bcd1,
  input  logic [3:0]           conv_bcd2,
  output logic                 busy,
  output logic                 disp_valid,
  output logic [2:0]           an_n,
  output logic [3:0]           digit,
  output logic                 blank
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t               state_q, state_d;
  logic [NUM_WIDTH-1:0] num_q, num_d;
  logic                 grant_q, grant_d;          // 1 = requester B
  logic                 last_grant_q, last_grant_d;
  logic                 ack_a_q, ack_a_d;
  logic                 ack_b_q, ack_b_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [3:0]           d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           sel_q, sel_d;
  logic [2:0]           an_n_q, an_n_d;
  logic [3:0]           digit_q, digit_d;
  logic                 blank_q, blank_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      num_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      d0_q         <= 4'h0;
      d1_q         <= 4'h0;
      d2_q         <= 4'h0;
      cnt_q        <= '0;
      sel_q        <= 2'd0;
      an_n_q       <= 3'b110;
      digit_q      <= 4'h0;
      blank_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      d0_q         <= d0_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      an_n_q       <= an_n_d;
      digit_q      <= digit_d;
      blank_q      <= blank_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    busy_d       = busy_q;
    valid_d      = valid_q;
    d0_d         = d0_q;
    d1_d         = d1_q;
    d2_d         = d2_q;

    case (state_q)
      IDLE: begin
        // On a tie A wins only if B was served last.
        if (req_a && (!req_b || last_grant_q)) begin
          num_d   = num_a;
          grant_d = 1'b0;
          busy_d  = 1'b1;
          state_d = CONV;
        end else if (req_b) begin
          num_d   = num_b;
          grant_d = 1'b1;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        d0_d    = conv_bcd0;
        d1_d    = conv_bcd1;
        d2_d    = conv_bcd2;
        valid_d = 1'b1;
        ack_a_d = ~grant_q;
        ack_b_d = grant_q;
        state_d = DONE;
      end
      DONE: begin
        last_grant_d = grant_q;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan outputs are registered from next-state values so they track the
  // display registers without an extra cycle of lag.
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    an_n_d  = 3'b110;
    digit_d = d0_d;
    case (sel_d)
      2'd0: begin an_n_d = 3'b110; digit_d = d0_d; end
      2'd1: begin an_n_d = 3'b101; digit_d = d1_d; end
      default: begin an_n_d = 3'b011; digit_d = d2_d; end
    endcase

    blank_d = 1'b0;
    if (!valid_d) begin
      blank_d = 1'b1;
    end else if (d2_d != 4'hF) begin
      case (sel_d)
        2'd2:    blank_d = (d2_d == 4'h0);
        2'd1:    blank_d = (d2_d == 4'h0) && (d1_d == 4'h0);
        default: blank_d = 1'b0;
      endcase
    end
  end

  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign conv_number = num_q;
  assign busy        = busy_q;
  assign disp_valid  = valid_q;
  assign an_n        = an_n_q;
  assign digit       = digit_q;
  assign blank       = blank_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl with a behavioural converter and an ack scoreboard.
module tb_bcd_display_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [9:0] num_a = '0, num_b = '0;
  logic       ack_a, ack_b, busy, disp_valid, blank;
  logic [9:0] conv_number;
  logic [3:0] conv_bcd0, conv_bcd1, conv_bcd2, digit;
  logic [2:0] an_n;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {bit who; logic [11:0] dig;} sb_t;
  sb_t sb[$];

  bcd_display_ctrl #(.REFRESH_DIV(4), .NUM_WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .num_a(num_a), .ack_a(ack_a),
    .req_b(req_b), .num_b(num_b), .ack_b(ack_b),
    .conv_number(conv_number),
    .conv_bcd0(conv_bcd0), .conv_bcd1(conv_bcd1), .conv_bcd2(conv_bcd2),
    .busy(busy), .disp_valid(disp_valid),
    .an_n(an_n), .digit(digit), .blank(blank)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] bcd(input int n);
    logic [11:0] r;
    if (n >= 640) r = 12'hFFF;
    else r = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    return r;
  endfunction

  logic [11:0] conv_out;
  assign conv_out  = bcd(int'(conv_number));
  assign conv_bcd0 = conv_out[3:0];
  assign conv_bcd1 = conv_out[7:4];
  assign conv_bcd2 = conv_out[11:8];

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each ack must match the oldest expected grant and digits.
  always @(negedge clk) begin
    if (!rst && (ack_a || ack_b)) begin
      chk(32'(sb.size() > 0), 1, "sb_unexpected_ack");
      if (sb.size() > 0) begin
        sb_t e;
        e = sb.pop_front();
        chk({30'd0, ack_b, ack_a}, e.who ? 32'd2 : 32'd1, "sb_ack_who");
        chk(32'(disp_valid), 1, "sb_disp_valid");
        case (an_n)
          3'b110:  chk(32'(digit), 32'(e.dig[3:0]),  "sb_digit_ones");
          3'b101:  chk(32'(digit), 32'(e.dig[7:4]),  "sb_digit_tens");
          3'b011:  chk(32'(digit), 32'(e.dig[11:8]), "sb_digit_hundreds");
          default: chk(32'(an_n), 32'b110, "sb_an_n_onehot");
        endcase
      end
    end
  end

  // Waits for the given ack; returns the number of negedges after the first one.
  task automatic wait_ack(input bit is_b, input string tag, output int lat);
    bit seen = 0;
    lat = -1;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) chk(32'(busy), 1, {tag, "_busy"});
      if ((is_b ? ack_b : ack_a) === 1'b1) begin
        seen = 1;
        lat = i;
      end
    end
    chk(32'(seen), 1, {tag, "_ack_timeout"});
  endtask

  task automatic run_single(input bit is_b, input int n, input string tag);
    int lat;
    sb.push_back('{who: is_b, dig: bcd(n)});
    if (is_b) begin num_b = 10'(n); req_b = 1'b1; end
    else begin num_a = 10'(n); req_a = 1'b1; end
    wait_ack(is_b, tag, lat);
    chk(32'(lat), 1, {tag, "_latency"});
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);
    chk({30'd0, ack_b, ack_a}, 0, {tag, "_ack_one_cycle"});
    @(negedge clk);
    chk(32'(busy), 0, {tag, "_busy_clear"});
  endtask

  task automatic scan_check(input logic [11:0] exp, input bit b2, input bit b1, input string tag);
    bit [2:0] seen = '0;
    logic [3:0] dg [3];
    logic bl [3];
    for (int i = 0; i < 16 && seen != 3'b111; i++) begin
      @(negedge clk);
      case (an_n)
        3'b110: begin seen[0] = 1; dg[0] = digit; bl[0] = blank; end
        3'b101: begin seen[1] = 1; dg[1] = digit; bl[1] = blank; end
        3'b011: begin seen[2] = 1; dg[2] = digit; bl[2] = blank; end
        default: chk(32'(an_n), 32'b110, {tag, "_an_n_illegal"});
      endcase
    end
    chk(32'(seen), 32'b111, {tag, "_all_digits_scanned"});
    if (seen == 3'b111) begin
      chk(32'(dg[0]), 32'(exp[3:0]),  {tag, "_d0"});
      chk(32'(dg[1]), 32'(exp[7:4]),  {tag, "_d1"});
      chk(32'(dg[2]), 32'(exp[11:8]), {tag, "_d2"});
      chk(32'(bl[0]), 0,              {tag, "_blank0"});
      chk(32'(bl[1]), 32'(b1),        {tag, "_blank1"});
      chk(32'(bl[2]), 32'(b2),        {tag, "_blank2"});
    end
  endtask

  initial begin
    int lat;
    int n_ack;
    int last_cyc;
    bit [2:0] scan_seen;

    // Reset values
    repeat (3) @(negedge clk);
    chk(32'(an_n), 32'b110, "rst_an_n");
    chk(32'(digit), 0, "rst_digit");
    chk(32'(blank), 0, "rst_blank");
    chk({29'd0, busy, ack_b, ack_a}, 0, "rst_busy_acks");
    chk(32'(disp_valid), 0, "rst_disp_valid");
    rst = 1'b0;

    // Idle after reset: blanked, no activity, scan still running
    scan_seen = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      case (an_n)
        3'b110: scan_seen[0] = 1;
        3'b101: scan_seen[1] = 1;
        3'b011: scan_seen[2] = 1;
        default: scan_seen = scan_seen;
      endcase
    end
    chk(32'(blank), 1, "idle_blank");
    chk(32'(disp_valid), 0, "idle_disp_valid");
    chk({29'd0, busy, ack_b, ack_a}, 0, "idle_busy_acks");
    chk(32'(scan_seen), 32'b111, "idle_scan_rotates");

    run_single(1'b0, 639, "a639");
    scan_check(bcd(639), 1'b0, 1'b0, "scan639");

    run_single(1'b0, 640, "a640");
    scan_check(12'hFFF, 1'b0, 1'b0, "scan640");
    run_single(1'b0, 1023, "a1023");
    scan_check(12'hFFF, 1'b0, 1'b0, "scan1023");

    run_single(1'b1, 7, "b7");
    scan_check(bcd(7), 1'b1, 1'b1, "scan7");
    run_single(1'b1, 50, "b50");
    scan_check(bcd(50), 1'b1, 1'b0, "scan50");

    // Both requesters held: last grant was B, so order is A, B, A, B
    sb.push_back('{who: 1'b0, dig: bcd(100)});
    sb.push_back('{who: 1'b1, dig: bcd(200)});
    sb.push_back('{who: 1'b0, dig: bcd(100)});
    sb.push_back('{who: 1'b1, dig: bcd(200)});
    num_a = 10'd100; num_b = 10'd200;
    req_a = 1'b1; req_b = 1'b1;
    n_ack = 0;
    last_cyc = 0;
    for (int i = 0; i < 40 && n_ack < 4; i++) begin
      @(negedge clk);
      if (ack_a || ack_b) begin
        if (n_ack > 0) chk(32'(cyc - last_cyc), 3, "rr_ack_spacing");
        last_cyc = cyc;
        n_ack++;
      end
    end
    chk(32'(n_ack), 4, "rr_ack_count");
    req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(negedge clk);
    chk(32'(busy), 0, "rr_idle");
    scan_check(bcd(200), 1'b0, 1'b0, "scan200");

    // Reset during CONV aborts the conversion
    num_a = 10'd321; req_a = 1'b1;
    @(negedge clk);
    chk(32'(busy), 1, "abort_in_conv");
    rst = 1'b1;
    #1;
    chk({30'd0, ack_a, disp_valid}, 0, "abort_ack_valid");
    chk(32'(busy), 0, "abort_busy");
    chk(32'(an_n), 32'b110, "abort_an_n");
    chk(32'(digit), 0, "abort_digit");
    repeat (2) begin
      @(negedge clk);
      chk(32'(ack_a), 0, "abort_no_ack");
    end
    sb.push_back('{who: 1'b0, dig: bcd(321)});
    rst = 1'b0;
    wait_ack(1'b0, "after_abort", lat);
    chk(32'(lat), 1, "after_abort_latency");
    req_a = 1'b0;
    repeat (2) @(negedge clk);
    scan_check(bcd(321), 1'b0, 1'b0, "scan321");

    chk(32'(sb.size()), 0, "sb_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
